alu_exec: RTL and testbench

Execute-stage arithmetic unit of the pipelined MIPS datapath. Consumes the 5-bit `ALUCtl` code and `Sign` flag produced by the ALU control decoder together with the two forwarded operands. Computes all single-cycle operations combinationally. Runs multiplication (`ALUCtl` = 5'b11111) as a 32-iteration shift-add sequence, stalling the front of the pipeline through the hazard unit until the product is ready.

---
 rtl/alu_exec_if.sv | 27 ++
 rtl/alu_exec.sv | 155 +++++++++++++++
 tb/tb_alu_exec.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Execute-stage ALU bus: operands and opcode in, result and hazard signals out.
interface alu_exec_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic [4:0]       ALUCtl;
  logic             Sign;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             out_valid;
  logic             stall;

  // Pipeline side: drives the instruction, observes the result
  modport master (
    output in_valid, ALUCtl, Sign, in1, in2,
    input  out, hi, zero, out_valid, stall
  );

  // ALU side
  modport slave (
    input  in_valid, ALUCtl, Sign, in1, in2,
    output out, hi, zero, out_valid, stall
  );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus a multi-cycle
// shift-add multiplier that stalls the pipeline front until the product is ready.
module alu_exec #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  alu_exec_if.slave bus
);

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SLT = 5'b00111;
  localparam logic [4:0] OP_NOR = 5'b01100;
  localparam logic [4:0] OP_XOR = 5'b01101;
  localparam logic [4:0] OP_SLL = 5'b10000;
  localparam logic [4:0] OP_SRL = 5'b11000;
  localparam logic [4:0] OP_SRA = 5'b11001;
  localparam logic [4:0] OP_MUL = 5'b11111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned   CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_hi;
  logic               r_neg;

  logic               w_is_mul;
  logic               w_start;
  logic [4:0]         w_shamt;
  logic               w_slt;
  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic               w_neg;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_out;
  logic               w_out_valid;
  logic               w_stall;

  assign w_is_mul = (bus.ALUCtl == OP_MUL);
  assign w_start  = (r_state == ST_IDLE) && bus.in_valid && w_is_mul;
  assign w_shamt  = bus.in1[4:0];
  assign w_slt    = bus.Sign ? ($signed(bus.in1) < $signed(bus.in2)) : (bus.in1 < bus.in2);

  // Signed multiply runs on magnitudes; the sign is reapplied to the final product
  assign w_mag1 = (bus.Sign && bus.in1[WIDTH-1]) ? (~bus.in1 + WIDTH'(1)) : bus.in1;
  assign w_mag2 = (bus.Sign && bus.in2[WIDTH-1]) ? (~bus.in2 + WIDTH'(1)) : bus.in2;
  assign w_neg  = bus.Sign && (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
  assign w_prod = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;

  // Single-cycle ALU result; unlisted codes behave as ADD
  always_comb begin
    w_alu = bus.in1 + bus.in2;
    case (bus.ALUCtl)
      OP_AND:  w_alu = bus.in1 & bus.in2;
      OP_OR:   w_alu = bus.in1 | bus.in2;
      OP_ADD:  w_alu = bus.in1 + bus.in2;
      OP_SUB:  w_alu = bus.in1 - bus.in2;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_slt};
      OP_NOR:  w_alu = ~(bus.in1 | bus.in2);
      OP_XOR:  w_alu = bus.in1 ^ bus.in2;
      OP_SLL:  w_alu = bus.in2 << w_shamt;
      OP_SRL:  w_alu = bus.in2 >> w_shamt;
      OP_SRA:  w_alu = $signed(bus.in2) >>> w_shamt;
      default: w_alu = bus.in1 + bus.in2;
    endcase
  end

  // Multiplier sequencer: capture in IDLE, WIDTH shift-add steps in BUSY, publish hi in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_acc    <= '0;
            r_neg    <= w_neg;
            r_cnt    <= '0;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mplier <= r_mplier >> 1;
          r_mcand  <= r_mcand << 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_hi    <= w_prod[2*WIDTH-1:WIDTH];
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result mux and hazard outputs; out is forced to 0 while a multiply is in flight
  always_comb begin
    w_out       = w_alu;
    w_out_valid = bus.in_valid;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mul) begin
          w_out       = '0;
          w_out_valid = 1'b0;
          w_stall     = bus.in_valid;
        end
      end
      ST_BUSY: begin
        w_out       = '0;
        w_out_valid = 1'b0;
        w_stall     = 1'b1;
      end
      ST_DONE: begin
        w_out       = w_prod[WIDTH-1:0];
        w_out_valid = 1'b1;
        w_stall     = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.out       = w_out;
  assign bus.zero      = (w_out == '0);
  assign bus.out_valid = w_out_valid;
  assign bus.stall     = w_stall;
  assign bus.hi        = r_hi;

endmodule

// File: tb/tb_alu_exec.sv
// Randomized self-checking bench for alu_exec against an arithmetic reference model.
module tb_alu_exec;

  localparam logic [4:0] MUL = 5'b11111;

  logic clk = 1'b0;
  logic reset;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_hi   = '0;
  int unsigned n_mul    = 0;

  alu_exec_if #(.WIDTH(32)) bus ();

  alu_exec #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference ALU computed straight from the opcode table
  function automatic logic [31:0] ref_alu(input logic [4:0] ctl, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sb;
    sb = b;
    case (ctl)
      5'b00000: return a & b;
      5'b00001: return a | b;
      5'b00110: return a - b;
      5'b00111: return s ? {31'd0, $signed(a) < $signed(b)} : {31'd0, a < b};
      5'b01100: return ~(a | b);
      5'b01101: return a ^ b;
      5'b10000: return b << a[4:0];
      5'b11000: return b >> a[4:0];
      5'b11001: return sb >>> a[4:0];
      default:  return a + b;
    endcase
  endfunction

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic drive(input logic v, input logic [4:0] ctl, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v;
    bus.ALUCtl   = ctl;
    bus.Sign     = s;
    bus.in1      = a;
    bus.in2      = b;
  endtask

  // Single-cycle op: result in the same cycle, no stall, hi untouched
  task automatic do_op(input string tag, input logic v, input logic [4:0] ctl, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e;
    drive(v, ctl, s, a, b);
    e = ref_alu(ctl, s, a, b);
    @(negedge clk);
    check({tag, "_stall"}, {63'd0, bus.stall}, 64'd0);
    check({tag, "_valid"}, {63'd0, bus.out_valid}, {63'd0, v});
    if (ctl != MUL) begin
      check({tag, "_out"}, {32'd0, bus.out}, {32'd0, e});
      check({tag, "_zero"}, {63'd0, bus.zero}, {63'd0, e == 32'd0});
    end
    check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
    @(posedge clk);
    #1;
  endtask

  // Multiply: count stall cycles, check DONE result, then hi after the DONE edge
  task automatic do_mul(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] p;
    int cycles;
    p = ref_mul(s, a, b);
    drive(1'b1, MUL, s, a, b);
    cycles = 0;
    @(negedge clk);
    while (bus.stall && cycles < 100) begin
      cycles++;
      if (cycles == 5) begin
        check({tag, "_busy_out"}, {32'd0, bus.out}, 64'd0);
        check({tag, "_busy_zero"}, {63'd0, bus.zero}, 64'd1);
        check({tag, "_busy_valid"}, {63'd0, bus.out_valid}, 64'd0);
      end
      @(negedge clk);
    end
    check({tag, "_stall_cycles"}, 64'(cycles), 64'd33);
    check({tag, "_out"}, {32'd0, bus.out}, {32'd0, p[31:0]});
    check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    check({tag, "_zero"}, {63'd0, bus.zero}, {63'd0, p[31:0] == 32'd0});
    @(posedge clk);
    #1;
    exp_hi = p[63:32];
    check({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
    n_mul++;
  endtask

  logic [4:0] codes [11];

  initial begin
    codes = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111, 5'b01100,
              5'b01101, 5'b10000, 5'b11000, 5'b11001, MUL};
    reset = 1'b1;
    drive(1'b0, 5'b00010, 1'b0, 32'd0, 32'd0);
    #3;
    check("rst_stall", {63'd0, bus.stall}, 64'd0);
    check("rst_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed ALU cases
    do_op("and", 1'b1, 5'b00000, 1'b0, 32'hC, 32'hA);
    do_op("or",  1'b1, 5'b00001, 1'b0, 32'hC, 32'hA);
    do_op("xor", 1'b1, 5'b01101, 1'b0, 32'hC, 32'hA);
    do_op("nor", 1'b1, 5'b01100, 1'b0, 32'hC, 32'hA);
    do_op("sub", 1'b1, 5'b00110, 1'b0, 32'hC, 32'hA);
    do_op("sub_eq", 1'b1, 5'b00110, 1'b0, 32'h1234, 32'h1234);
    do_op("slt_s", 1'b1, 5'b00111, 1'b1, 32'hFFFF_FFFF, 32'd1);
    do_op("slt_u", 1'b1, 5'b00111, 1'b0, 32'hFFFF_FFFF, 32'd1);
    do_op("srl", 1'b1, 5'b11000, 1'b0, 32'd4, 32'h8000_0000);
    do_op("sra", 1'b1, 5'b11001, 1'b0, 32'd4, 32'h8000_0000);
    do_op("sll", 1'b1, 5'b10000, 1'b0, 32'd4, 32'd1);
    do_op("undef", 1'b1, 5'b10101, 1'b0, 32'd7, 32'd9);
    do_op("mul_bubble", 1'b0, MUL, 1'b0, 32'd3, 32'd4);

    // Directed multiplies, including back-to-back
    do_mul("mul_s", 1'b1, 32'hFFFF_FFFD, 32'd7);
    do_mul("mul_u", 1'b0, 32'hFFFF_FFFF, 32'd2);
    do_mul("mul_b2b", 1'b0, 32'd5, 32'd6);

    // Randomized mix
    for (int i = 0; i < 200; i++) begin
      logic [4:0]  c;
      logic [31:0] a, b;
      logic        s, v;
      c = ($urandom_range(0, 9) == 0) ? 5'($urandom) : codes[$urandom_range(0, 10)];
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      s = 1'($urandom);
      v = ($urandom_range(0, 7) != 0);
      if (c == MUL && v) begin
        if (n_mul < 12) do_mul("rnd_mul", s, a, b);
        else do_op("rnd_op", v, 5'b00010, s, a, b);
      end else begin
        do_op("rnd_op", v, c, s, a, b);
      end
    end

    // Abort a multiply with reset once the counter reaches 10
    drive(1'b1, MUL, 1'b0, 32'd123, 32'd456);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("abort_stall", {63'd0, bus.stall}, 64'd0);
    check("abort_hi", {32'd0, bus.hi}, 64'd0);
    check("abort_valid", {63'd0, bus.out_valid}, 64'd0);
    exp_hi = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_abort_stall", {63'd0, bus.stall}, 64'd0);
    @(posedge clk);
    #1;
    do_op("post_abort_add", 1'b1, 5'b00010, 1'b0, 32'd40, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
